// File: rtl/miriscv_data_mem.sv
// rtl/miriscv_data_mem.sv - data RAM with cycle-counter and LED register window
// Word-addressed RAM plus two MMIO words; reads have one cycle of latency.
module miriscv_data_mem #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] MMIO_ADDR = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        err_o,
  output logic [15:0] led_o
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  localparam logic [29:0] CNT_WA    = MMIO_ADDR[31:2];
  localparam logic [29:0] LED_WA    = CNT_WA + 30'd1;

  logic [31:0] mem [DEPTH];

  logic [31:0] off;
  logic [AW-1:0] idx;
  logic        ram_hit, cnt_hit, led_hit, miss, rd, wr;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cnt_q;
  logic [31:0] led_q, led_d;
  logic        err_q, err_d;

  always_comb begin
    off     = data_addr_i - BASE_ADDR;
    idx     = off[AW+1:2];
    ram_hit = off < RAM_BYTES;
    cnt_hit = data_addr_i[31:2] == CNT_WA;
    led_hit = data_addr_i[31:2] == LED_WA;
    miss    = ~(ram_hit | cnt_hit | led_hit);
    rd      = data_req_i & ~data_we_i;
    wr      = data_req_i & data_we_i;

    rdata_d = rdata_q;
    if (rd) begin
      if (ram_hit)      rdata_d = mem[idx];
      else if (cnt_hit) rdata_d = cnt_q;
      else if (led_hit) rdata_d = led_q;
      else              rdata_d = 32'h0;
    end

    led_d = led_q;
    for (int n = 0; n < 4; n++) begin
      if (wr && led_hit && data_be_i[n]) led_d[8*n +: 8] = data_wdata_i[8*n +: 8];
    end

    // Writes to the counter word are silently dropped and do not count as a miss.
    err_d = err_q | (data_req_i & miss);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rdata_q <= 32'h0;
      cnt_q   <= 32'h0;
      led_q   <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      cnt_q   <= cnt_q + 32'd1;
      led_q   <= led_d;
      err_q   <= err_d;
    end
  end

  // RAM has no reset; writes are merely blocked while reset is held.
  always_ff @(posedge clk_i) begin
    if (wr && ram_hit && !arst_i) begin
      for (int n = 0; n < 4; n++) begin
        if (data_be_i[n]) mem[idx][8*n +: 8] <= data_wdata_i[8*n +: 8];
      end
    end
  end

  assign data_rdata_o = rdata_q;
  assign err_o        = err_q;
  assign led_o        = led_q[15:0];

endmodule

// File: tb/tb_miriscv_data_mem.sv
// tb/tb_miriscv_data_mem.sv - self-checking bench for miriscv_data_mem
// Directed steps plus a randomized phase against a word-level reference model.
module tb_miriscv_data_mem;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] MMIO  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        arst;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        err_o;
  logic [15:0] led_o;

  always #5 clk = ~clk;

  miriscv_data_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .MMIO_ADDR(MMIO)) dut (
    .clk_i(clk), .arst_i(arst), .data_req_i(data_req_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rdata_o(data_rdata_o), .err_o(err_o), .led_o(led_o)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_mem [int unsigned];
  logic [31:0] m_rdata, m_led, m_cnt;
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rq, input logic we, input logic [3:0] be,
                            input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] off, mask;
    int unsigned wi;
    logic ram, cnt, led;
    if (arst) begin
      m_rdata = 0; m_err = 0; m_led = 0; m_cnt = 0;
      return;
    end
    off  = a - BASE;
    ram  = off < DEPTH * 4;
    wi   = off >> 2;
    cnt  = (a >> 2) == (MMIO >> 2);
    led  = (a >> 2) == (MMIO >> 2) + 1;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (rq && !we) begin
      if (ram)      m_rdata = m_mem[wi];
      else if (cnt) m_rdata = m_cnt;
      else if (led) m_rdata = m_led;
      else begin m_rdata = 0; m_err = 1; end
    end else if (rq && we) begin
      if (ram)      m_mem[wi] = (m_mem[wi] & ~mask) | (wd & mask);
      else if (led) m_led = (m_led & ~mask) | (wd & mask);
      else if (!cnt) m_err = 1;
    end
    m_cnt = m_cnt + 1;
  endtask

  task automatic cyc(input logic rq, input logic we, input logic [3:0] be,
                     input logic [31:0] a, input logic [31:0] wd);
    data_req_i = rq; data_we_i = we; data_be_i = be; data_addr_i = a; data_wdata_i = wd;
    @(posedge clk);
    model_edge(rq, we, be, a, wd);
    #1;
    chk("rdata", data_rdata_o, m_rdata);
    chk("err", {31'b0, err_o}, {31'b0, m_err});
    chk("led", {16'b0, led_o}, {16'b0, m_led[15:0]});
    data_req_i = 1'b0; data_we_i = 1'b0;
  endtask

  task automatic rd_w(input logic [31:0] a);
    cyc(1'b1, 1'b0, 4'h0, a, 32'h0);
  endtask

  task automatic wr_w(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    cyc(1'b1, 1'b1, be, a, d);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    arst = 1'b1;
    data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
    m_rdata = 0; m_err = 0; m_led = 0; m_cnt = 0;
    #12;
    chk("reset_rdata", data_rdata_o, 32'h0);
    chk("reset_err", {31'b0, err_o}, 32'h0);
    chk("reset_led", {16'b0, led_o}, 32'h0);

    // Counter: the first edge after release reads 0, the second reads 1.
    @(negedge clk); arst = 1'b0; m_cnt = 0;
    rd_w(MMIO);
    chk("cnt_first", data_rdata_o, 32'd0);
    rd_w(MMIO);
    chk("cnt_second", data_rdata_o, 32'd1);

    for (int i = 0; i < 17; i++) wr_w(BASE + 32'(i * 4), 4'hF, (i == 16) ? 32'h0 : $urandom);
    wr_w(BASE + (DEPTH - 1) * 4, 4'hF, $urandom);
    rd_w(BASE + (DEPTH - 1) * 4 + 3);

    wr_w(BASE + 8, 4'hF, 32'hDEAD_BEEF);
    rd_w(BASE + 8);
    chk("deadbeef", data_rdata_o, 32'hDEAD_BEEF);
    repeat (3) idle();
    chk("deadbeef_hold", data_rdata_o, 32'hDEAD_BEEF);

    wr_w(BASE + 64, 4'b0001, 32'h0000_00AA);
    wr_w(BASE + 64, 4'b0100, 32'h00BB_0000);
    rd_w(BASE + 64);
    chk("byte_merge", data_rdata_o, 32'h00BB_00AA);

    wr_w(MMIO + 4, 4'hF, 32'h1234_5678);
    chk("led_out", {16'b0, led_o}, 32'h0000_5678);
    rd_w(MMIO + 4);
    chk("led_read", data_rdata_o, 32'h1234_5678);
    wr_w(MMIO, 4'hF, 32'h5555_5555);
    chk("cnt_write_no_err", {31'b0, err_o}, 32'h0);
    rd_w(MMIO);

    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    rd_w(MMIO);
    chk("cnt_max", data_rdata_o, 32'hFFFF_FFFF);
    rd_w(MMIO);
    chk("cnt_wrap", data_rdata_o, 32'h0);

    for (int n = 0; n < 300; n++) begin
      int unsigned op;
      logic [31:0] a;
      op = $urandom_range(0, 6);
      a  = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      case (op)
        0, 1: rd_w(a);
        2, 3: wr_w(a, 4'($urandom), $urandom);
        4:    if ($urandom_range(0, 1) == 1) rd_w(MMIO + 4); else wr_w(MMIO + 4, 4'($urandom), $urandom);
        5:    if ($urandom_range(0, 1) == 1) rd_w(MMIO); else wr_w(MMIO, 4'($urandom), $urandom);
        default: idle();
      endcase
    end

    rd_w(BASE + DEPTH * 4);
    chk("miss_rdata", data_rdata_o, 32'h0);
    chk("miss_err", {31'b0, err_o}, 32'h1);
    wr_w(MMIO + 8, 4'hF, 32'hFFFF_FFFF);
    for (int n = 0; n < 20; n++) rd_w(BASE + 32'($urandom_range(0, 15) * 4));
    chk("err_sticky", {31'b0, err_o}, 32'h1);

    wr_w(BASE + 12, 4'hF, 32'hCAFE_F00D);
    rd_w(BASE + 12);
    chk("cafe_read", data_rdata_o, 32'hCAFE_F00D);
    #2 arst = 1'b1;
    #1;
    chk("async_rdata", data_rdata_o, 32'h0);
    chk("async_led", {16'b0, led_o}, 32'h0);
    chk("async_err", {31'b0, err_o}, 32'h0);
    wr_w(MMIO + 4, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk); arst = 1'b0; m_cnt = 0;
    rd_w(MMIO);
    chk("cnt_after_reset", data_rdata_o, 32'h0);
    rd_w(BASE + 12);
    chk("ram_survives_reset", data_rdata_o, 32'hCAFE_F00D);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
